data_bus_responder: RTL and testbench



---
 rtl/data_bus_responder.sv | 163 ++++++++++++++++
 tb/tb_data_bus_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/data_bus_responder.sv
// rtl/data_bus_responder.sv - processor data-port responder: RAM and memory-mapped I/O with wait-request stall
module data_bus_responder #(
    parameter int RAM_LATENCY = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] DataAddr,
    input  logic [15:0] DataOut,
    input  logic        WriteData,
    input  logic        ReadData,
    output logic [15:0] DataIn,
    output logic        DataWaitreq,
    output logic [11:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    input  logic [15:0] ram_q,
    input  logic [9:0]  SW,
    input  logic [3:0]  KEY,
    output logic [9:0]  LEDR,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);

    localparam int CNT_W = (RAM_LATENCY < 2) ? 1 : $clog2(RAM_LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic               is_write_q, is_write_d;
    logic [15:0]        din_q, din_d;
    logic [9:0]         ledr_q, ledr_d;
    logic [6:0]         hex_q [6];
    logic [6:0]         hex_d [6];
    logic [9:0]         sw_meta_q, sw_sync_q;
    logic [3:0]         key_meta_q, key_sync_q;

    logic               req;
    logic [3:0]         region_q;
    logic [2:0]         sel_q;
    logic [6:0]         hex_rd;
    logic [15:0]        rd_data;

    assign req      = ReadData | WriteData;
    assign region_q = addr_q[15:12];
    assign sel_q    = addr_q[2:0];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            din_q      <= '0;
            ledr_q     <= '0;
            for (int i = 0; i < 6; i++) hex_q[i] <= 7'h7F;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            key_meta_q <= '0;
            key_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            din_q      <= din_d;
            ledr_q     <= ledr_d;
            hex_q      <= hex_d;
            sw_meta_q  <= SW;
            sw_sync_q  <= sw_meta_q;
            key_meta_q <= KEY;
            key_sync_q <= key_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req) state_d = S_ACCESS;
            S_ACCESS: if (cnt_q == '0) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ram_we is purely a function of state, so an async reset drops it at once
    always_comb begin
        ram_we      = 1'b0;
        DataWaitreq = 1'b0;
        case (state_q)
            S_IDLE:   DataWaitreq = req;
            S_ACCESS: begin
                DataWaitreq = req;
                ram_we      = is_write_q && (region_q == 4'h0);
            end
            default: ;
        endcase
    end

    always_comb begin
        hex_rd = 7'h00;
        for (int i = 0; i < 6; i++) begin
            if (sel_q == 3'(i)) hex_rd = hex_q[i];
        end
        case (region_q)
            4'h0:    rd_data = ram_q;
            4'h1:    rd_data = {6'b0, ledr_q};
            4'h2:    rd_data = {9'b0, hex_rd};
            4'h3:    rd_data = addr_q[0] ? {12'b0, key_sync_q} : {6'b0, sw_sync_q};
            default: rd_data = 16'h0000;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        cnt_d      = cnt_q;
        din_d      = din_q;
        ledr_d     = ledr_q;
        hex_d      = hex_q;
        if (state_q == S_IDLE && req) begin
            // write wins when both request lines are high
            addr_d     = DataAddr;
            wdata_d    = DataOut;
            is_write_d = WriteData;
            cnt_d      = (!WriteData && DataAddr[15:12] == 4'h0) ? CNT_W'(RAM_LATENCY) : '0;
        end else if (state_q == S_ACCESS) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (is_write_q) begin
                if (region_q == 4'h1) ledr_d = wdata_q[9:0];
                if (region_q == 4'h2) begin
                    for (int i = 0; i < 6; i++) begin
                        if (sel_q == 3'(i)) hex_d[i] = wdata_q[6:0];
                    end
                end
            end else begin
                din_d = rd_data;
            end
        end
    end

    assign DataIn    = din_q;
    assign LEDR      = ledr_q;
    assign HEX0      = hex_q[0];
    assign HEX1      = hex_q[1];
    assign HEX2      = hex_q[2];
    assign HEX3      = hex_q[3];
    assign HEX4      = hex_q[4];
    assign HEX5      = hex_q[5];
    assign ram_addr  = addr_q[11:0];
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// tb/tb_data_bus_responder.sv - scoreboard bench for data_bus_responder
module tb_data_bus_responder;

    localparam int LAT = 1;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] DataAddr, DataOut, DataIn, ram_wdata, ram_q;
    logic        WriteData, ReadData, DataWaitreq, ram_we;
    logic [11:0] ram_addr;
    logic [9:0]  SW, LEDR;
    logic [3:0]  KEY;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    data_bus_responder #(.RAM_LATENCY(LAT)) dut (
        .Clock(Clock), .Reset(Reset), .DataAddr(DataAddr), .DataOut(DataOut),
        .WriteData(WriteData), .ReadData(ReadData), .DataIn(DataIn),
        .DataWaitreq(DataWaitreq), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_q(ram_q), .SW(SW), .KEY(KEY), .LEDR(LEDR),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    always #5 Clock = ~Clock;

    logic [15:0] mem [4096];
    always @(posedge Clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    typedef struct {
        logic [15:0] din;
        logic [9:0]  ledr;
        int          stall;
        int          we;
        logic [11:0] waddr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] din, input logic [9:0] ledr,
                                input int stall, input int we, input logic [11:0] waddr);
        exp_t e;
        e.din = din; e.ledr = ledr; e.stall = stall; e.we = we; e.waddr = waddr;
        return e;
    endfunction

    // monitor: a completion is the DONE cycle, where a request is up but the stall is down
    int          stall_n = 0;
    int          we_n = 0;
    int          we_pos = -1;
    logic [11:0] we_addr = '0;
    exp_t        e_mon;
    always @(negedge Clock) begin
        if (Reset || !(ReadData | WriteData)) begin
            stall_n = 0;
            we_n    = 0;
        end else begin
            if (ram_we) begin
                we_n++;
                we_pos  = stall_n;
                we_addr = ram_addr;
            end
            if (DataWaitreq) begin
                stall_n++;
            end else begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_completion", 1, 0);
                end else begin
                    e_mon = sb_q.pop_front();
                    chk("DataIn", DataIn, e_mon.din);
                    chk("LEDR", LEDR, e_mon.ledr);
                    chk("stall_cycles", stall_n, e_mon.stall);
                    chk("ram_we_cycles", we_n, e_mon.we);
                    if (e_mon.we != 0) begin
                        chk("ram_we_addr", we_addr, e_mon.waddr);
                        chk("ram_we_cycle_index", we_pos, 1);
                    end
                end
                stall_n = 0;
                we_n    = 0;
            end
        end
    end

    task automatic access(input logic we, input logic re, input logic [15:0] addr,
                          input logic [15:0] wd, input exp_t e);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        sb_q.push_back(e);
        WriteData = we;
        ReadData  = re;
        DataAddr  = addr;
        DataOut   = wd;
        while (!done && n < 20) begin
            @(posedge Clock); #1;
            n++;
            if (!DataWaitreq) done = 1;
        end
        if (!done) chk("timeout", 0, 1);
        @(posedge Clock); #1;
        WriteData = 0;
        ReadData  = 0;
    endtask

    // reset lands in the single ACCESS cycle of a write
    task automatic abort_write(input logic [15:0] addr, input logic [15:0] wd, input logic exp_we);
        WriteData = 1;
        DataAddr  = addr;
        DataOut   = wd;
        @(posedge Clock); #1;
        chk("abort_we_before_reset", ram_we, exp_we);
        Reset = 1;
        #1;
        chk("abort_we_after_reset", ram_we, 0);
        chk("abort_LEDR", LEDR, 0);
        chk("abort_HEX3", HEX3, 7'h7F);
        WriteData = 0;
        @(posedge Clock); #1;
        Reset = 0;
        chk("abort_waitreq", DataWaitreq, 0);
        repeat (3) @(posedge Clock);
        #1;
        chk("abort_LEDR_later", LEDR, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        Reset = 1; WriteData = 0; ReadData = 0; DataAddr = '0; DataOut = '0;
        SW = '0; KEY = '0;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_DataIn", DataIn, 0);
        chk("rst_LEDR", LEDR, 0);
        chk("rst_HEX", {HEX0, HEX1, HEX2, HEX3, HEX4, HEX5}, {6{7'h7F}});
        chk("rst_ram_we", ram_we, 0);
        chk("rst_waitreq", DataWaitreq, 0);
        Reset = 0;
        @(posedge Clock); #1;

        access(1, 0, 16'h0123, 16'hBEEF, mk(16'h0000, 10'h000, 2, 1, 12'h123));
        access(0, 1, 16'h0123, 16'h0000, mk(16'hBEEF, 10'h000, LAT + 2, 0, 0));
        access(1, 0, 16'h1000, 16'h02AA, mk(16'hBEEF, 10'h2AA, 2, 0, 0));
        access(1, 0, 16'h2003, 16'h0040, mk(16'hBEEF, 10'h2AA, 2, 0, 0));
        chk("HEX3_written", HEX3, 7'h40);
        chk("HEX0_untouched", HEX0, 7'h7F);
        access(1, 0, 16'h2006, 16'h0000, mk(16'hBEEF, 10'h2AA, 2, 0, 0));
        access(0, 1, 16'h2003, 16'h0000, mk(16'h0040, 10'h2AA, 2, 0, 0));
        access(0, 1, 16'h2006, 16'h0000, mk(16'h0000, 10'h2AA, 2, 0, 0));

        SW = 10'h155; KEY = 4'hA;
        repeat (2) @(posedge Clock);
        #1;
        access(0, 1, 16'h3000, 16'h0000, mk(16'h0155, 10'h2AA, 2, 0, 0));
        access(0, 1, 16'h3001, 16'h0000, mk(16'h000A, 10'h2AA, 2, 0, 0));
        access(1, 1, 16'h1000, 16'h0001, mk(16'h000A, 10'h001, 2, 0, 0));
        access(0, 1, 16'h5000, 16'h0000, mk(16'h0000, 10'h001, 2, 0, 0));

        access(1, 0, 16'h0000, 16'h1111, mk(16'h0000, 10'h001, 2, 1, 12'h000));
        access(1, 0, 16'h0FFF, 16'h2222, mk(16'h0000, 10'h001, 2, 1, 12'hFFF));
        access(0, 1, 16'h0000, 16'h0000, mk(16'h1111, 10'h001, LAT + 2, 0, 0));
        access(0, 1, 16'h0FFF, 16'h0000, mk(16'h2222, 10'h001, LAT + 2, 0, 0));
        access(0, 1, 16'h0000, 16'h0000, mk(16'h1111, 10'h001, LAT + 2, 0, 0));

        abort_write(16'h1000, 16'h03FF, 1'b0);
        access(1, 0, 16'h0050, 16'h1234, mk(16'h0000, 10'h000, 2, 1, 12'h050));
        abort_write(16'h0050, 16'h9999, 1'b1);
        access(0, 1, 16'h0050, 16'h0000, mk(16'h1234, 10'h000, LAT + 2, 0, 0));

        repeat (4) @(posedge Clock);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
